// File: rtl/bolme_pkg.sv
// rtl/bolme_pkg.sv - shared constants and types for the divider
// Purpose : default operand width, operation encodings and FSM states
//           shared by bolme_birimi and anything that drives it.
// Ports   : none (package).
package bolme_pkg;

  localparam int XLEN_DEF = 32;

  // islem_i[1] set means a signed operation, islem_i[0] set means remainder.
  typedef enum logic [1:0] {
    DIVU = 2'b00,
    REMU = 2'b01,
    DIV  = 2'b10,
    REM  = 2'b11
  } islem_e;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } durum_e;

endpackage

// File: rtl/bolme_birimi.sv
// rtl/bolme_birimi.sv - iterative radix-2 restoring integer divider
// Purpose : DIVU/REMU/DIV/REM with a fixed 32-step iteration per operation,
//           RISC-V style divide-by-zero and signed-overflow results.
// Ports   : clk_i      clock, all state changes on the rising edge
//           rst_i      synchronous active-high reset
//           basla_i    start request, sampled only in IDLE
//           islem_i    operation select (DIVU, REMU, DIV, REM)
//           bolunen_i  dividend
//           bolen_i    divisor
//           sonuc_o    registered result, held until the next completion
//           bitti_o    one-cycle done pulse coincident with a new sonuc_o
module bolme_birimi
  import bolme_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            basla_i,
  input  logic [1:0]      islem_i,
  input  logic [XLEN-1:0] bolunen_i,
  input  logic [XLEN-1:0] bolen_i,
  output logic [XLEN-1:0] sonuc_o,
  output logic            bitti_o
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] SON_ADIM = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] EN_KUCUK = {1'b1, {(XLEN-1){1'b0}}};

  durum_e          durum_q, durum_d;
  islem_e          islem_q;
  logic [XLEN-1:0] bolum_q;   // holds dividend magnitude, quotient bits shift in at LSB
  logic [XLEN-1:0] kalan_q;
  logic [XLEN-1:0] bolen_q;
  logic [CW-1:0]   sayac_q;
  logic            bolum_isaret_q, kalan_isaret_q, sifir_q, tasma_q;

  // Operand capture helpers.
  logic            isaretli;
  logic [XLEN-1:0] bolunen_mut, bolen_mut;

  always_comb begin
    isaretli    = islem_i[1];
    bolunen_mut = (isaretli && bolunen_i[XLEN-1]) ? (~bolunen_i + 1'b1) : bolunen_i;
    bolen_mut   = (isaretli && bolen_i[XLEN-1])   ? (~bolen_i + 1'b1)   : bolen_i;
  end

  // One restoring step. The shifted remainder needs one extra bit and the
  // subtraction one more so the borrow is visible for any divisor value.
  logic [XLEN:0]   kaydir;
  logic [XLEN+1:0] fark;
  logic            odunc;
  logic [XLEN-1:0] kalan_d, bolum_d;

  always_comb begin
    kaydir  = {kalan_q, bolum_q[XLEN-1]};
    fark    = {1'b0, kaydir} - {2'b00, bolen_q};
    odunc   = fark[XLEN+1];
    kalan_d = odunc ? kaydir[XLEN-1:0] : fark[XLEN-1:0];
    bolum_d = {bolum_q[XLEN-2:0], ~odunc};
  end

  // Sign correction and special-case selection for the final write.
  // A zero divisor naturally yields an all-ones quotient and the dividend
  // magnitude as remainder; the explicit selects keep the signed forms right.
  logic [XLEN-1:0] bolum_son, kalan_son, sonuc_d;

  always_comb begin
    bolum_son = bolum_isaret_q ? (~bolum_d + 1'b1) : bolum_d;
    kalan_son = kalan_isaret_q ? (~kalan_d + 1'b1) : kalan_d;
    sonuc_d   = '0;
    case (islem_q)
      DIVU:    sonuc_d = sifir_q ? '1 : bolum_d;
      REMU:    sonuc_d = kalan_d;
      DIV:     sonuc_d = sifir_q ? '1 : (tasma_q ? EN_KUCUK : bolum_son);
      REM:     sonuc_d = tasma_q ? '0 : kalan_son;
      default: sonuc_d = '0;
    endcase
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      IDLE:    if (basla_i) durum_d = CALC;
      CALC:    if (sayac_q == SON_ADIM) durum_d = IDLE;
      default: durum_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q        <= IDLE;
      islem_q        <= DIVU;
      bolum_q        <= '0;
      kalan_q        <= '0;
      bolen_q        <= '0;
      sayac_q        <= '0;
      bolum_isaret_q <= 1'b0;
      kalan_isaret_q <= 1'b0;
      sifir_q        <= 1'b0;
      tasma_q        <= 1'b0;
      sonuc_o        <= '0;
      bitti_o        <= 1'b0;
    end else begin
      durum_q <= durum_d;
      bitti_o <= 1'b0;
      case (durum_q)
        IDLE: begin
          if (basla_i) begin
            islem_q        <= islem_e'(islem_i);
            bolum_q        <= bolunen_mut;
            kalan_q        <= '0;
            bolen_q        <= bolen_mut;
            sayac_q        <= '0;
            bolum_isaret_q <= isaretli & (bolunen_i[XLEN-1] ^ bolen_i[XLEN-1]);
            kalan_isaret_q <= isaretli & bolunen_i[XLEN-1];
            sifir_q        <= (bolen_i == '0);
            tasma_q        <= isaretli && (bolunen_i == EN_KUCUK) && (bolen_i == '1);
          end
        end
        CALC: begin
          bolum_q <= bolum_d;
          kalan_q <= kalan_d;
          sayac_q <= sayac_q + 1'b1;
          if (sayac_q == SON_ADIM) begin
            sonuc_o <= sonuc_d;
            bitti_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// tb/tb_bolme_birimi.sv - directed self-checking bench for bolme_birimi
module tb_bolme_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        basla_i = 1'b0;
  logic [1:0]  islem_i = 2'b00;
  logic [31:0] bolunen_i = '0;
  logic [31:0] bolen_i = '0;
  logic [31:0] sonuc_o;
  logic        bitti_o;

  int total = 0;
  int bad = 0;

  bolme_birimi dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .basla_i   (basla_i),
    .islem_i   (islem_i),
    .bolunen_i (bolunen_i),
    .bolen_i   (bolen_i),
    .sonuc_o   (sonuc_o),
    .bitti_o   (bitti_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    total++;
    if (gozlenen !== beklenen) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic kenar();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for bitti_o after the accepting edge; returns number of edges seen.
  task automatic bitti_bekle(output int n);
    n = 0;
    do begin
      kenar();
      n++;
    end while (!bitti_o && n < 100);
  endtask

  // Accepting edge plus 32 step edges: done appears after the 32nd edge
  // following the accepting one (the 33rd edge counting the accepting edge).
  localparam int GECIKME = 32;

  task automatic islem_yap(input string etiket, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] beklenen);
    int n;
    islem_i   = op;
    bolunen_i = a;
    bolen_i   = b;
    basla_i   = 1'b1;
    kenar();
    basla_i   = 1'b0;
    bitti_bekle(n);
    kontrol({etiket, " latency"}, 32'(n), 32'(GECIKME));
    kontrol(etiket, sonuc_o, beklenen);
  endtask

  typedef struct {
    string       ad;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vektor_t;

  vektor_t tablo[$] = '{
    '{"divu 41/9",      2'b00, 32'd41,         32'd9,          32'd4},
    '{"divu 9/41",      2'b00, 32'd9,          32'd41,         32'd0},
    '{"divu big/9",     2'b00, 32'hFFFF_FFD7,  32'd9,          32'd477218583},
    '{"divu 41/big",    2'b00, 32'd41,         32'hFFFF_FFF7,  32'd0},
    '{"div 41/9",       2'b10, 32'd41,         32'd9,          32'd4},
    '{"div -41/9",      2'b10, 32'hFFFF_FFD7,  32'd9,          32'hFFFF_FFFC},
    '{"div 41/-9",      2'b10, 32'd41,         32'hFFFF_FFF7,  32'hFFFF_FFFC},
    '{"div 9/41",       2'b10, 32'd9,          32'd41,         32'd0},
    '{"div ovf",        2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{"remu 41/9",      2'b01, 32'd41,         32'd9,          32'd5},
    '{"remu 9/41",      2'b01, 32'd9,          32'd41,         32'd9},
    '{"remu big/9",     2'b01, 32'hFFFF_FFD7,  32'd9,          32'd8},
    '{"remu 41/big",    2'b01, 32'd41,         32'hFFFF_FFF7,  32'd41},
    '{"rem 41/9",       2'b11, 32'd41,         32'd9,          32'd5},
    '{"rem -41/9",      2'b11, 32'hFFFF_FFD7,  32'd9,          32'hFFFF_FFFB},
    '{"rem 41/-9",      2'b11, 32'd41,         32'hFFFF_FFF7,  32'd5},
    '{"rem ovf",        2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
    '{"divu 41/0",      2'b00, 32'd41,         32'd0,          32'hFFFF_FFFF},
    '{"div 41/0",       2'b10, 32'd41,         32'd0,          32'hFFFF_FFFF},
    '{"remu 41/0",      2'b01, 32'd41,         32'd0,          32'd41},
    '{"rem 41/0",       2'b11, 32'd41,         32'd0,          32'd41},
    '{"div -41/0",      2'b10, 32'hFFFF_FFD7,  32'd0,          32'hFFFF_FFFF},
    '{"rem -41/0",      2'b11, 32'hFFFF_FFD7,  32'd0,          32'hFFFF_FFD7}
  };

  initial begin
    int n;
    int darbe;

    kenar();
    kenar();
    kontrol("reset sonuc", sonuc_o, 32'd0);
    kontrol("reset bitti", {31'd0, bitti_o}, 32'd0);
    rst_i = 1'b0;
    kenar();

    foreach (tablo[i]) islem_yap(tablo[i].ad, tablo[i].op, tablo[i].a, tablo[i].b, tablo[i].q);

    kenar();
    kontrol("bitti one cycle", {31'd0, bitti_o}, 32'd0);
    kontrol("sonuc held", sonuc_o, 32'hFFFF_FFD7);

    // Back-to-back with basla_i held high and operands changed mid-CALC.
    islem_i   = 2'b00;
    bolunen_i = 32'd100;
    bolen_i   = 32'd7;
    basla_i   = 1'b1;
    kenar();
    bolunen_i = 32'd1000;
    bolen_i   = 32'd3;
    islem_i   = 2'b01;
    kenar();
    kontrol("b2b hold mid", sonuc_o, 32'hFFFF_FFD7);
    bitti_bekle(n);
    kontrol("b2b1 latency", 32'(n + 1), 32'(GECIKME));
    kontrol("b2b1 divu 100/7", sonuc_o, 32'd14);
    kenar();
    // second op accepted on that edge with 1000/3 REMU
    basla_i   = 1'b0;
    bolunen_i = 32'd5;
    bolen_i   = 32'd5;
    islem_i   = 2'b10;
    bitti_bekle(n);
    kontrol("b2b2 latency", 32'(n), 32'(GECIKME));
    kontrol("b2b2 remu 1000/3", sonuc_o, 32'd1);

    // Reset mid-CALC, with basla_i high on the reset edge.
    islem_i   = 2'b00;
    bolunen_i = 32'd41;
    bolen_i   = 32'd9;
    basla_i   = 1'b1;
    kenar();
    for (int k = 0; k < 10; k++) kenar();
    rst_i = 1'b1;
    kenar();
    rst_i   = 1'b0;
    basla_i = 1'b0;
    kontrol("abort sonuc", sonuc_o, 32'd0);
    darbe = 0;
    for (int k = 0; k < 40; k++) begin
      kenar();
      if (bitti_o) darbe++;
    end
    kontrol("abort no pulse", 32'(darbe), 32'd0);
    kontrol("abort sonuc kept", sonuc_o, 32'd0);

    islem_yap("after reset div -41/9", 2'b10, 32'hFFFF_FFD7, 32'd9, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
